// File: rtl/signmag_seg_display.sv
// rtl/signmag_seg_display.sv - sign-magnitude to BCD, 4-digit multiplexed 7-seg driver (option: LEADING_ZERO_BLANK_EN)
`timescale 1ns/1ps

module signmag_seg_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] value,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_LOAD
    } state_t;

    state_t     state;
    logic [7:0] mag_sr;
    logic [11:0] bcd_sr;
    logic [11:0] bcd_adj;
    logic [2:0] iter;
    logic       sign_q;

    logic       disp_sign;
    logic [3:0] disp_h;
    logic [3:0] disp_t;
    logic [3:0] disp_o;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       idx;
    logic [6:0]       digit_seg;
    logic             blank_h;
    logic             blank_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        bcd_adj = {add3(bcd_sr[11:8]), add3(bcd_sr[7:4]), add3(bcd_sr[3:0])};
    end

    // Sign is normalised at latch time so that -0 can never reach the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mag_sr    <= '0;
            bcd_sr    <= '0;
            iter      <= '0;
            sign_q    <= 1'b0;
            disp_sign <= 1'b0;
            disp_h    <= '0;
            disp_t    <= '0;
            disp_o    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mag_sr <= value[7:0];
                        sign_q <= value[8] & (|value[7:0]);
                        bcd_sr <= '0;
                        iter   <= '0;
                        busy   <= 1'b1;
                        state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {bcd_sr, mag_sr} <= {bcd_adj, mag_sr} << 1;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    disp_h    <= bcd_sr[11:8];
                    disp_t    <= bcd_sr[7:4];
                    disp_o    <= bcd_sr[3:0];
                    disp_sign <= sign_q;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        blank_h = (disp_h == 4'd0);
        blank_t = (disp_h == 4'd0) && (disp_t == 4'd0);
`else
        blank_h = 1'b0;
        blank_t = 1'b0;
`endif
    end

    always_comb begin
        digit_seg = SEG_BLANK;
        case (idx)
            2'd0: digit_seg = seg_of(disp_o);
            2'd1: digit_seg = blank_t ? SEG_BLANK : seg_of(disp_t);
            2'd2: digit_seg = blank_h ? SEG_BLANK : seg_of(disp_h);
            2'd3: digit_seg = disp_sign ? SEG_MINUS : SEG_BLANK;
            default: digit_seg = SEG_BLANK;
        endcase
    end

    // an/seg are registered from idx, so they trail the index by one cycle
    // but each digit still stays lit for exactly SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= '0;
            seg     <= SEG_BLANK;
            an      <= 4'b1111;
        end else begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            an  <= ~(4'b0001 << idx);
            seg <= digit_seg;
        end
    end

endmodule

// File: tb/tb_signmag_seg_display.sv
// tb/tb_signmag_seg_display.sv - randomized self-checking bench for signmag_seg_display
`timescale 1ns/1ps

module tb_signmag_seg_display;

    localparam int SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] value = '0;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [3:0] an;

    signmag_seg_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .seg   (seg),
        .an    (an)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected pattern for digit position pos (0 ones .. 3 sign) of a 9-bit sign-magnitude value.
    function automatic logic [6:0] exp_seg(input int v, input int pos);
        int mag, h, t, o;
        bit neg;
        mag = v % 256;
        neg = (v >= 256) && (mag != 0);
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        case (pos)
            3: return neg ? MINUS : BLANK;
            2: return (LZB && h == 0) ? BLANK : SEG_TAB[h];
            1: return (LZB && h == 0 && t == 0) ? BLANK : SEG_TAB[t];
            default: return SEG_TAB[o];
        endcase
    endfunction

    int cyc;
    int disp_model;
    int pend[$];
    int mon_d;
    logic [3:0] mon_an;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Scan and display monitor: the digit shown at cycle c is ((c-1)/SCAN_DIV)%4,
    // showing the value loaded by the last done seen before that edge.
    always @(negedge clk) begin
        if (!rst_n || cyc == 0) begin
            check_eq("an_reset", an, 4'hF);
            check_eq("seg_reset", seg, BLANK);
            if (!rst_n) begin
                disp_model = 0;
                pend.delete();
            end
        end else begin
            mon_d  = ((cyc - 1) / SCAN_DIV) % 4;
            mon_an = ~(4'b0001 << mon_d);
            check_eq("an_scan", an, mon_an);
            check_eq("seg_digit", seg, exp_seg(disp_model, mon_d));
        end
        if (rst_n && done) begin
            check_eq("done_expected", pend.size() > 0, 1);
            if (pend.size() > 0) disp_model = pend.pop_front();
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with busy low; returns at the negedge where done is high.
    task automatic run_conv(input logic [8:0] v, input bit inject);
        check_eq("busy_before", busy, 1'b0);
        value = v;
        start = 1'b1;
        pend.push_back(int'(v));
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check_eq("busy_conv", busy, 1'b1);
            check_eq("done_early", done, 1'b0);
            if (inject && i == 3) begin
                value = 9'($urandom_range(0, 511));
                start = 1'b1;
            end
            if (i == 4) start = 1'b0;
        end
        @(negedge clk);
        check_eq("done_pulse", done, 1'b1);
        check_eq("busy_done", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(8 * SCAN_DIV);

        run_conv(9'h0FF, 1'b0); idle(4 * SCAN_DIV + 2);
        run_conv(9'h107, 1'b0); idle(4 * SCAN_DIV + 2);
        run_conv(9'h100, 1'b0); idle(4 * SCAN_DIV + 2);
        run_conv(9'h000, 1'b0); idle(4 * SCAN_DIV + 2);
        run_conv(9'h080, 1'b1);
        run_conv(9'h02A, 1'b0); idle(4 * SCAN_DIV + 2);

        for (int n = 0; n < 40; n++) begin
            run_conv(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 20));
        end

        // Reset in the middle of a +200 conversion.
        value = 9'd200;
        start = 1'b1;
        pend.push_back(200);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("busy_async_rst", busy, 1'b0);
        check_eq("done_async_rst", done, 1'b0);
        check_eq("an_async_rst", an, 4'hF);
        check_eq("seg_async_rst", seg, BLANK);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_eq("busy_after_rst", busy, 1'b0);
        end

        run_conv(9'(200), 1'b0); idle(4 * SCAN_DIV + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signmag_seg_display.md
# signmag_seg_display

Sequential display back-end for the 7-segment calculator. It consumes the 9-bit sign-magnitude result produced by the arithmetic units (bit 8 = sign, bits 7:0 = unsigned magnitude 0..255). It converts the magnitude to three BCD digits with an 8-step shift-add-3 (double-dabble) FSM, holds the result in display registers, and time-multiplexes four common-anode digits: sign, hundreds, tens, ones.

## Interface
Parameters:
- SCAN_DIV, default 50000: clock cycles each digit stays enabled; legal range ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load strobe; sampled only while busy = 0.
- value  in  9  sign-magnitude operand; [8] = sign (1 = negative), [7:0] = magnitude.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse when the new value reaches the display registers.
- seg  out  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- an  out  4  digit enables, active-low; an[0] = ones, an[1] = tens, an[2] = hundreds, an[3] = sign.

## Operation
- Conversion FSM states: IDLE, CONV, LOAD.
  - IDLE: on start = 1, latch value, clear the BCD shift register and the iteration counter, then go to CONV.
  - CONV: 8 iterations, one per cycle. Each iteration first adds 3 to every BCD nibble that is ≥ 5, then shifts {bcd[11:0], mag[7:0]} left by 1. After iteration 8, go to LOAD.
  - LOAD: copy the hundreds, tens and ones nibbles and the sign into the display registers, pulse done, return to IDLE.
- Sign normalisation: if the latched magnitude is 0, the stored sign is forced to 0, so -0 displays as 0.
- start while busy = 1 is ignored. The latched operand is not disturbed.
- The display registers change only in LOAD. The scan keeps showing the previous value during a conversion.
- Scan logic:
  - A free-running divider counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0→1→2→3→0.
  - seg and an are registered from the current index and the display registers.
- Segment patterns (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, minus=0111111, blank=1111111.
- Sign digit: minus when the stored sign = 1, blank otherwise.
- BCD nibbles above 9 cannot occur for magnitudes 0..255. If one does occur, seg shows blank.

## Timing
- Reset (async assert): FSM → IDLE, busy = 0, done = 0, display registers = 0 (positive zero), divider = 0, index = 0, seg = 1111111, an = 1111.
- First clock after reset release: an = 1110, seg shows ones digit "0".
- start sampled high at edge T (busy = 0):
  - busy = 1 for the 9 cycles following T (8 CONV + 1 LOAD).
  - done = 1 for exactly the cycle after the LOAD edge, which is 10 edges after T.
  - busy = 0 in that same cycle, so a new start can be accepted on the same edge where done is high.
- The new digit pattern appears on seg on the first edge after done rises, provided the corresponding digit is enabled.
- Digit switch: an and seg change on the same edge. Each digit is enabled for exactly SCAN_DIV cycles, giving a full refresh every 4·SCAN_DIV cycles.
- Reset asserted mid-conversion: the conversion is aborted, nothing is loaded, and no done pulse is issued.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Hundreds digit is blank when it is 0.
  - Tens digit is blank when both hundreds and tens are 0.
  - Ones digit is never blanked.
  - The sign digit stays in the fixed an[3] position.
- Undefined: all three numeric digits are always shown, e.g. 7 shows "007".

## Test plan
- Reset, no start, SCAN_DIV = 4 → an cycles 1110,1101,1011,0111 every 4 cycles. seg = 1000000 on numeric digits and 1111111 on the sign digit.
- start with value = 9'h0FF (+255) → busy for 9 cycles, done exactly 10 edges after start. Display shows blank, 2, 5, 5 (seg 1111111, 0100100, 0010010, 0010010).
- value = 9'h107 (-7) → sign digit 0111111. With LEADING_ZERO_BLANK_EN: hundreds and tens are 1111111, ones is 1111000. Without it: 1000000, 1000000, 1111000.
- value = 9'h100 (-0) → sign digit blank, ones digit 1000000.
- Second start 3 cycles into a conversion of +128 → ignored; result is 1,2,8 with a single done pulse. A start on the done cycle with +42 is accepted, and its done follows 10 edges later.
- rst_n low 5 cycles after start of +200 → busy and done drop immediately, the display returns to positive zero, and no done pulse follows.
